pio_edge_irq_debounce: RTL
==========================

PIO_EDGE_IRQ_DEBOUNCE -- requirements
Module: pio_edge_irq_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of input channels (legal range 1..16).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000, cycles an input must hold a new level before acceptance (legal range at least 1).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port address  input  2  register select.
REQ-006 Port chipselect  input  1  slave select.
REQ-007 Port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-008 Port writedata  input  32  write data.
REQ-009 Port in_port  input  WIDTH  asynchronous button/switch inputs.
REQ-010 Port readdata  output  32  registered read data.
REQ-011 Port irq  output  1  interrupt request, level.

Function
REQ-012 Register map SHALL be: addr 0 = debounced data (RO); addr 1 = edge enable (rise_en in bits [WIDTH-1:0], fall_en in bits [WIDTH+15:16]); addr 2 = irq_mask [WIDTH-1:0]; addr 3 = edge_capture [WIDTH-1:0].
REQ-013 readdata SHALL update every cycle with the addressed register, zero-extended, unused bits 0; latency one cycle; chipselect not required for reads.
REQ-014 Each in_port bit SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-015 Each channel SHALL have a counter of width $clog2(DEBOUNCE_CYCLES+1): cleared when sync2 == stable; incremented when sync2 != stable and count < DEBOUNCE_CYCLES-1; when sync2 != stable and count == DEBOUNCE_CYCLES-1, stable <= sync2 and count <= 0.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL clear the counter and leave stable unchanged.
REQ-017 stable_d SHALL register stable every cycle; rise event = stable & ~stable_d & rise_en; fall event = ~stable & stable_d & fall_en.
REQ-018 edge_capture bit SHALL be set on the cycle after stable changes if the matching event is enabled; both enables set = any-edge mode.
REQ-019 Write to addr 3 SHALL clear each edge_capture bit whose writedata bit is 1 (write-1-to-clear); bits written 0 unchanged.
REQ-020 Simultaneous clear-write and new event on the same bit SHALL leave the bit set (set wins).
REQ-021 Writes to addr 0 SHALL be ignored; writes to addr 1/2 SHALL take effect on the next edge.
REQ-022 irq SHALL equal OR of (edge_capture & irq_mask), combinational from registers.
REQ-023 Latency: level change on in_port before edge k SHALL reach stable at edge k+1+DEBOUNCE_CYCLES and edge_capture at edge k+2+DEBOUNCE_CYCLES, provided the input holds.

Reset
REQ-024 Reset SHALL asynchronously clear sync1, sync2, stable, stable_d, all counters, rise_en, fall_en, irq_mask, edge_capture and readdata to 0; irq SHALL be 0 during reset.
REQ-025 Input held high across reset release SHALL propagate to stable without setting edge_capture, since enables are 0 after reset.
REQ-026 Reset asserted mid-count SHALL discard the count; counting restarts from 0 after release.

Configuration
REQ-027 With macro PIO_DEBOUNCE_EN defined, counters SHALL be implemented per REQ-015/016.
REQ-028 Without PIO_DEBOUNCE_EN, counters SHALL be absent and stable SHALL equal sync2 (stable at edge k+1, capture at edge k+2); DEBOUNCE_CYCLES SHALL be ignored.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, PIO_DEBOUNCE_EN defined unless stated)
REQ-029 Write addr1=0x0000_0001, addr2=0x1; raise in_port[0] before edge 10 and hold -> addr0 bit0=1 after edge 15, edge_capture=0x1 and irq=1 after edge 16.
REQ-030 Pulse in_port[1] high for 3 cycles with rise_en[1]=1 -> stable, edge_capture and irq unchanged (0).
REQ-031 fall_en=0x4 (addr1=0x0004_0000); drive in_port[2] 1 then 0, each held 10 cycles -> only falling transition sets edge_capture=0x4; irq stays 0 while irq_mask=0.
REQ-032 edge_capture=0xF; write addr3=0x5 -> read 0xA one cycle later; same-cycle clear of bit1 with new bit1 event -> bit1 stays 1.
REQ-033 in_port=0xF held through reset release, enables 0 -> addr0 reads 0xF, edge_capture 0; reset pulse mid-count -> all registers 0.
REQ-034 PIO_DEBOUNCE_EN undefined: rise_en=0x1, raise in_port[0] before edge 10 -> edge_capture=0x1 after edge 12; 1-cycle glitch also captured.

Source files
------------

// File: rtl/pio_edge_irq_debounce_if.sv
// Register-bus bundle for the debounced PIO block: address/strobe/data in, registered read data out.
interface pio_edge_irq_debounce_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_edge_irq_debounce.sv
// Debounced PIO with per-channel rise/fall edge capture, W1C capture register and masked level IRQ.
// Define PIO_DEBOUNCE_EN to build the per-channel debounce counters; otherwise stable follows sync2.
module pio_edge_irq_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  pio_edge_irq_debounce_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] events;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] count [WIDTH];

  // Any return of sync2 to the accepted level restarts the hold window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          count[i]  <= '0;
        end else begin
          count[i] <= count[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign stable = sync2;
`endif

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign events   = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
  assign clr_mask = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (bus.address)
      2'd0: rd_next[WIDTH-1:0] = stable;
      2'd1: begin
        rd_next[WIDTH-1:0]   = rise_en;
        rd_next[WIDTH+15:16] = fall_en;
      end
      2'd2:    rd_next[WIDTH-1:0] = irq_mask;
      default: rd_next[WIDTH-1:0] = edge_capture;
    endcase
  end

  // New events are OR-ed in after the clear so a same-cycle event survives the W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d     <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      bus.readdata <= '0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~clr_mask) | events;
      bus.readdata <= rd_next;
      if (wr_en && bus.address == 2'd1) begin
        rise_en <= bus.writedata[WIDTH-1:0];
        fall_en <= bus.writedata[WIDTH+15:16];
      end
      if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
